tpc_warp_dispatch: RTL and testbench

- TPC-side initiator for the SM warp-assign handshake: the opposite end of each SM core's warp request/response port.
- Accepts one kernel launch, defined by a warp count, from the upstream kernel scheduler.
- Issues warp requests round-robin across NUM_SM SM cores, each honouring its SM's request-ready.
- Collects completed-warp responses from all SMs and pulses kernel_done_o when every dispatched warp has completed.

---
 rtl/tpc_warp_dispatch_pkg.sv | 26 ++
 rtl/tpc_rr_pick.sv | 50 +++++
 rtl/tpc_warp_dispatch.sv | 135 +++++++++++++
 tb/tb_tpc_warp_dispatch.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_warp_dispatch_pkg.sv
// Shared definitions for the TPC warp dispatcher: SM count, counter width and the
// 2-bit dispatcher state encoding.
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif
`ifndef NUM_SM
`define NUM_SM 4
`endif
`ifndef TPC_CNT_WIDTH
`define TPC_CNT_WIDTH 16
`endif

package tpc_warp_dispatch_pkg;

  localparam int unsigned TPC_NUM_SM     = `NUM_SM;
  localparam int unsigned TPC_CNT_WIDTH  = `TPC_CNT_WIDTH;
  localparam int unsigned TPC_DEPTH_WARP = `DEPTH_WARP;

  typedef logic [1:0] tpc_state_t;

  localparam tpc_state_t TPC_ST_IDLE     = 2'd0;
  localparam tpc_state_t TPC_ST_DISPATCH = 2'd1;
  localparam tpc_state_t TPC_ST_DRAIN    = 2'd2;
  localparam tpc_state_t TPC_ST_DONE     = 2'd3;

endpackage

// File: rtl/tpc_rr_pick.sv
// Round-robin picker: grants the first requester at or after the pointer, with wrap-around.
// The pointer moves past the granted index only when the grant is consumed.
module tpc_rr_pick #(
  parameter int unsigned NUM_SM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SM-1:0]   req,
  input  logic                fire,
  output logic [NUM_SM-1:0]   grant,
  output logic [(NUM_SM > 1 ? $clog2(NUM_SM) : 1)-1:0] idx
);

  localparam int unsigned IdxW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      cand = IdxW'((int'(ptr_q) + i) % int'(NUM_SM));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (idx == IdxW'(NUM_SM - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tpc_warp_dispatch.sv
// TPC-side warp dispatcher: accepts one kernel, issues its warps round-robin to the SM cores
// and pulses kernel_done_o once every issued warp has reported completion.
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif

module tpc_warp_dispatch
  import tpc_warp_dispatch_pkg::*;
#(
  parameter int unsigned NUM_SM    = TPC_NUM_SM,
  parameter int unsigned CNT_WIDTH = TPC_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           kernel_valid_i,
  output logic                           kernel_ready_o,
  input  logic [CNT_WIDTH-1:0]           kernel_num_warp_i,
  output logic                           kernel_done_o,
  output logic                           busy_o,
  output logic [NUM_SM-1:0]              sm_req_valid_o,
  input  logic [NUM_SM-1:0]              sm_req_ready_i,
  input  logic [NUM_SM-1:0]              sm_rsp_valid_i,
  output logic [NUM_SM-1:0]              sm_rsp_ready_o,
  input  logic [NUM_SM*`DEPTH_WARP-1:0]  sm_rsp_wid_i,
  output logic [CNT_WIDTH-1:0]           issued_cnt_o,
  output logic [CNT_WIDTH-1:0]           done_cnt_o
);

  localparam int unsigned IdxW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  tpc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] num_warp_q, num_warp_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] done_q, done_d;

  logic [NUM_SM-1:0]    pick_req;
  logic [NUM_SM-1:0]    grant;
  logic [IdxW-1:0]      unused_pick_idx;
  logic                 issue_fire;
  logic                 in_flight;
  logic [NUM_SM-1:0]    rsp_fire;
  logic [CNT_WIDTH:0]   rsp_cnt;
  logic [CNT_WIDTH:0]   done_sum;
  logic [CNT_WIDTH-1:0] issued_inc;
  logic [CNT_WIDTH-1:0] done_clamp;
  logic                 unused_rsp_wid;

  // Completed warp ids are trace-only; they never influence counting.
  assign unused_rsp_wid = ^sm_rsp_wid_i;

  assign in_flight = (state_q == TPC_ST_DISPATCH) || (state_q == TPC_ST_DRAIN);
  assign pick_req  = (state_q == TPC_ST_DISPATCH) ? sm_req_ready_i : '0;

  tpc_rr_pick #(
    .NUM_SM (NUM_SM)
  ) u_rr_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (pick_req),
    .fire  (issue_fire),
    .grant (grant),
    .idx   (unused_pick_idx)
  );

  assign sm_req_valid_o = grant;
  assign issue_fire     = |(grant & sm_req_ready_i);
  assign sm_rsp_ready_o = {NUM_SM{in_flight}};
  assign rsp_fire       = sm_rsp_valid_i & sm_rsp_ready_o;

  always_comb begin
    rsp_cnt = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      rsp_cnt = rsp_cnt + (CNT_WIDTH + 1)'(rsp_fire[i]);
    end
  end

  // Completions beyond what has been issued (this cycle's issue included) are dropped.
  assign issued_inc = issued_q + CNT_WIDTH'(issue_fire);
  assign done_sum   = {1'b0, done_q} + rsp_cnt;
  assign done_clamp = (done_sum > {1'b0, issued_inc}) ? issued_inc : done_sum[CNT_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    num_warp_d = num_warp_q;
    issued_d   = issued_q;
    done_d     = done_q;
    case (state_q)
      TPC_ST_IDLE: begin
        if (kernel_valid_i) begin
          num_warp_d = kernel_num_warp_i;
          issued_d   = '0;
          done_d     = '0;
          state_d    = (kernel_num_warp_i == '0) ? TPC_ST_DONE : TPC_ST_DISPATCH;
        end
      end
      TPC_ST_DISPATCH: begin
        issued_d = issued_inc;
        done_d   = done_clamp;
        if (issue_fire && (issued_inc == num_warp_q)) begin
          state_d = (done_clamp == num_warp_q) ? TPC_ST_DONE : TPC_ST_DRAIN;
        end
      end
      TPC_ST_DRAIN: begin
        done_d = done_clamp;
        if (done_clamp == num_warp_q) begin
          state_d = TPC_ST_DONE;
        end
      end
      default: begin
        state_d = TPC_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TPC_ST_IDLE;
      num_warp_q <= '0;
      issued_q   <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_warp_q <= num_warp_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
    end
  end

  assign kernel_ready_o = (state_q == TPC_ST_IDLE);
  assign busy_o         = (state_q != TPC_ST_IDLE);
  assign kernel_done_o  = (state_q == TPC_ST_DONE);
  assign issued_cnt_o   = issued_q;
  assign done_cnt_o     = done_q;

endmodule

// File: tb/tb_tpc_warp_dispatch.sv
// Directed bench for tpc_warp_dispatch: inputs change 1ns after the rising edge,
// outputs are compared on the falling edge.
module tb_tpc_warp_dispatch;

  localparam int unsigned NSM = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned DW  = tpc_warp_dispatch_pkg::TPC_DEPTH_WARP;

  logic              clk;
  logic              rst_n;
  logic              kernel_valid_i;
  logic              kernel_ready_o;
  logic [CW-1:0]     kernel_num_warp_i;
  logic              kernel_done_o;
  logic              busy_o;
  logic [NSM-1:0]    sm_req_valid_o;
  logic [NSM-1:0]    sm_req_ready_i;
  logic [NSM-1:0]    sm_rsp_valid_i;
  logic [NSM-1:0]    sm_rsp_ready_o;
  logic [NSM*DW-1:0] sm_rsp_wid_i;
  logic [CW-1:0]     issued_cnt_o;
  logic [CW-1:0]     done_cnt_o;

  int checks;
  int errors;

  tpc_warp_dispatch #(
    .NUM_SM    (NSM),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .kernel_valid_i    (kernel_valid_i),
    .kernel_ready_o    (kernel_ready_o),
    .kernel_num_warp_i (kernel_num_warp_i),
    .kernel_done_o     (kernel_done_o),
    .busy_o            (busy_o),
    .sm_req_valid_o    (sm_req_valid_o),
    .sm_req_ready_i    (sm_req_ready_i),
    .sm_rsp_valid_i    (sm_rsp_valid_i),
    .sm_rsp_ready_o    (sm_rsp_ready_o),
    .sm_rsp_wid_i      (sm_rsp_wid_i),
    .issued_cnt_o      (issued_cnt_o),
    .done_cnt_o        (done_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: completions accepted in a cycle must never exceed warps outstanding.
  always @(negedge clk) begin
    logic [NSM-1:0] fires;
    int pop;
    int avail;
    fires = sm_rsp_valid_i & sm_rsp_ready_o;
    if (rst_n && (|fires)) begin
      pop = 0;
      for (int i = 0; i < NSM; i++) pop += int'(fires[i]);
      avail = int'(issued_cnt_o) + int'(|(sm_req_valid_o & sm_req_ready_i)) - int'(done_cnt_o);
      checks++;
      if (pop > avail) begin
        errors++;
        $display("FAIL rsp_overrun got %0d completions, at most %0d outstanding", pop, avail);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds kernel_valid_i for one edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [CW-1:0] n);
    kernel_valid_i    = 1'b1;
    kernel_num_warp_i = n;
    tick();
    kernel_valid_i    = 1'b0;
    kernel_num_warp_i = '0;
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    kernel_valid_i    = 1'b0;
    kernel_num_warp_i = '0;
    sm_req_ready_i    = '0;
    sm_rsp_valid_i    = '0;
    sm_rsp_wid_i      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_status got %b want 100", {kernel_ready_o, busy_o, kernel_done_o});
    end
    checks++;
    if ({sm_req_valid_o, sm_rsp_ready_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_handshake got %h want 00", {sm_req_valid_o, sm_rsp_ready_o});
    end
    checks++;
    if ({issued_cnt_o, done_cnt_o} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts got %h want 00000000", {issued_cnt_o, done_cnt_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_warps();
    sm_req_ready_i = 4'hF;
    launch(16'd0);
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o} !== 7'b011_0000) begin
      errors++;
      $display("FAIL zero_done got %b want 0110000",
               {kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o} !== 7'b100_0000) begin
      errors++;
      $display("FAIL zero_idle got %b want 1000000",
               {kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o});
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NSM-1:0] exp;
    sm_req_ready_i = 4'hF;
    launch(16'd8);
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (sm_req_valid_o !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d got %b want %b", k, sm_req_valid_o, exp);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({issued_cnt_o, sm_req_valid_o, sm_rsp_ready_o, busy_o, kernel_done_o} !==
        {16'd8, 4'b0000, 4'b1111, 2'b10}) begin
      errors++;
      $display("FAIL rr_drain got issued=%0d req=%b rsp_rdy=%b busy=%b done=%b want 8 0000 1111 1 0",
               issued_cnt_o, sm_req_valid_o, sm_rsp_ready_o, busy_o, kernel_done_o);
    end
    tick();
    sm_rsp_valid_i = 4'hF;
    tick();
    @(negedge clk);
    checks++;
    if ({done_cnt_o, kernel_done_o} !== {16'd4, 1'b0}) begin
      errors++;
      $display("FAIL rr_half got done_cnt=%0d done=%b want 4 0", done_cnt_o, kernel_done_o);
    end
    tick();
    sm_rsp_valid_i = 4'h0;
    @(negedge clk);
    checks++;
    if ({done_cnt_o, kernel_done_o, busy_o} !== {16'd8, 2'b11}) begin
      errors++;
      $display("FAIL rr_done got done_cnt=%0d done=%b busy=%b want 8 1 1",
               done_cnt_o, kernel_done_o, busy_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o} !== 3'b100) begin
      errors++;
      $display("FAIL rr_idle got %b want 100", {kernel_ready_o, busy_o, kernel_done_o});
    end
    tick();
  endtask

  task automatic test_single_sm();
    sm_req_ready_i = 4'b0100;
    launch(16'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (sm_req_valid_o !== 4'b0100) begin
        errors++;
        $display("FAIL single_grant%0d got %b want 0100", k, sm_req_valid_o);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({issued_cnt_o, sm_req_valid_o, busy_o} !== {16'd3, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL single_drain got issued=%0d req=%b busy=%b want 3 0000 1",
               issued_cnt_o, sm_req_valid_o, busy_o);
    end
    tick();
    sm_rsp_valid_i = 4'b0111;
    tick();
    sm_rsp_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if ({done_cnt_o, kernel_done_o} !== {16'd3, 1'b1}) begin
      errors++;
      $display("FAIL single_done got done_cnt=%0d done=%b want 3 1", done_cnt_o, kernel_done_o);
    end
    tick();
  endtask

  // Pointer rests at 3 after the single-SM kernel, so grants start at SM3.
  task automatic test_concurrent();
    logic [NSM-1:0] exp_tbl [4];
    exp_tbl = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    tick();
    sm_req_ready_i = 4'hF;
    launch(16'd6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sm_req_valid_o !== exp_tbl[k]) begin
        errors++;
        $display("FAIL conc_grant%0d got %b want %b", k, sm_req_valid_o, exp_tbl[k]);
      end
      tick();
    end
    sm_rsp_valid_i = 4'hF;
    @(negedge clk);
    checks++;
    if ({sm_req_valid_o, issued_cnt_o, done_cnt_o} !== {4'b1000, 16'd4, 16'd0}) begin
      errors++;
      $display("FAIL conc_pre got req=%b issued=%0d done_cnt=%0d want 1000 4 0",
               sm_req_valid_o, issued_cnt_o, done_cnt_o);
    end
    tick();
    sm_rsp_valid_i = 4'h0;
    @(negedge clk);
    checks++;
    if ({issued_cnt_o, done_cnt_o, sm_req_valid_o} !== {16'd5, 16'd4, 4'b0001}) begin
      errors++;
      $display("FAIL conc_same_cycle got issued=%0d done_cnt=%0d req=%b want 5 4 0001",
               issued_cnt_o, done_cnt_o, sm_req_valid_o);
    end
    tick();
    sm_rsp_valid_i = 4'b0011;
    @(negedge clk);
    checks++;
    if ({issued_cnt_o, sm_req_valid_o, kernel_done_o} !== {16'd6, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL conc_drain got issued=%0d req=%b done=%b want 6 0000 0",
               issued_cnt_o, sm_req_valid_o, kernel_done_o);
    end
    tick();
    sm_rsp_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if ({done_cnt_o, kernel_done_o} !== {16'd6, 1'b1}) begin
      errors++;
      $display("FAIL conc_done got done_cnt=%0d done=%b want 6 1", done_cnt_o, kernel_done_o);
    end
    tick();
  endtask

  // Pointer is 1 here; the only warp issues and completes in the same cycle.
  task automatic test_same_cycle_finish();
    tick();
    sm_req_ready_i = 4'b0010;
    launch(16'd1);
    sm_rsp_valid_i = 4'b0010;
    @(negedge clk);
    checks++;
    if ({sm_req_valid_o, sm_rsp_ready_o, kernel_done_o} !== {4'b0010, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL n1_dispatch got req=%b rsp_rdy=%b done=%b want 0010 1111 0",
               sm_req_valid_o, sm_rsp_ready_o, kernel_done_o);
    end
    tick();
    sm_rsp_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if ({kernel_done_o, issued_cnt_o, done_cnt_o, sm_rsp_ready_o} !==
        {1'b1, 16'd1, 16'd1, 4'b0000}) begin
      errors++;
      $display("FAIL n1_done got done=%b issued=%0d done_cnt=%0d rsp_rdy=%b want 1 1 1 0000",
               kernel_done_o, issued_cnt_o, done_cnt_o, sm_rsp_ready_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, kernel_done_o} !== 2'b10) begin
      errors++;
      $display("FAIL n1_idle got ready=%b done=%b want 1 0", kernel_ready_o, kernel_done_o);
    end
    tick();
  endtask

  // Pointer is 2 here. Reset lands while draining with 5 issued and 2 done.
  task automatic test_reset_mid_drain();
    logic [NSM-1:0] exp_tbl [5];
    exp_tbl = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    sm_req_ready_i = 4'hF;
    launch(16'd5);
    for (int k = 0; k < 5; k++) begin
      sm_rsp_valid_i = (k == 2) ? 4'b0011 : 4'b0000;
      @(negedge clk);
      checks++;
      if (sm_req_valid_o !== exp_tbl[k]) begin
        errors++;
        $display("FAIL mid_grant%0d got %b want %b", k, sm_req_valid_o, exp_tbl[k]);
      end
      tick();
    end
    sm_rsp_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if ({issued_cnt_o, done_cnt_o, busy_o, sm_req_valid_o} !== {16'd5, 16'd2, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL mid_drain got issued=%0d done_cnt=%0d busy=%b req=%b want 5 2 1 0000",
               issued_cnt_o, done_cnt_o, busy_o, sm_req_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o, sm_rsp_ready_o,
         issued_cnt_o, done_cnt_o} !== {3'b100, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b busy=%b done=%b req=%b rsp_rdy=%b issued=%0d done_cnt=%0d",
               kernel_ready_o, busy_o, kernel_done_o, sm_req_valid_o, sm_rsp_ready_o,
               issued_cnt_o, done_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    launch(16'd2);
    @(negedge clk);
    checks++;
    if (sm_req_valid_o !== 4'b0001) begin
      errors++;
      $display("FAIL post_grant0 got %b want 0001", sm_req_valid_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (sm_req_valid_o !== 4'b0010) begin
      errors++;
      $display("FAIL post_grant1 got %b want 0010", sm_req_valid_o);
    end
    tick();
    sm_rsp_valid_i = 4'b0011;
    tick();
    sm_rsp_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if ({kernel_done_o, issued_cnt_o, done_cnt_o} !== {1'b1, 16'd2, 16'd2}) begin
      errors++;
      $display("FAIL post_done got done=%b issued=%0d done_cnt=%0d want 1 2 2",
               kernel_done_o, issued_cnt_o, done_cnt_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({kernel_ready_o, busy_o, kernel_done_o} !== 3'b100) begin
      errors++;
      $display("FAIL post_idle got %b want 100", {kernel_ready_o, busy_o, kernel_done_o});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_warps();
    test_round_robin();
    test_single_sm();
    test_concurrent();
    test_same_cycle_finish();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no summary within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
